// File: rtl/operand_pkg.sv
// rtl/operand_pkg.sv - shared types, constants and helpers for operand_pipe
// Purpose: operation-mode encoding, shifter kind selection, immediate width
//          and the immediate shift-amount helper used by operand_pipe.
// Ports:   none (package).
package operand_pkg;

  localparam int IMM_W = 21;

  typedef enum logic [3:0] {
    MODE_PASS     = 4'd0,
    MODE_IMM11    = 4'd1,
    MODE_IMM14    = 4'd2,
    MODE_IMM21    = 4'd3,
    MODE_SHRL     = 4'd4,
    MODE_SHRA     = 4'd5,
    MODE_SHL      = 4'd6,
    MODE_ZERO     = 4'd7,
    MODE_SHRL_SAR = 4'd8,
    MODE_SHRA_SAR = 4'd9,
    MODE_SHL_SAR  = 4'd10,
    MODE_SHRP     = 4'd11
  } op_mode_e;

  typedef enum logic [1:0] {
    SH_LOGIC = 2'd0,
    SH_ARITH = 2'd1,
    SH_LEFT  = 2'd2,
    SH_PAIR  = 2'd3
  } shift_kind_e;

  // The instruction encodes the complement of the shift distance in I[5+:SHW];
  // amt_field is I[10:5], and only the low SHW bits matter for the width.
  function automatic logic [5:0] calc_sh_imm(input logic [5:0] amt_field, input int width);
    logic [5:0] mask;
    logic [5:0] field;
    mask  = (width == 64) ? 6'd63 : 6'd31;
    field = amt_field & mask;
    return mask - field;
  endfunction

endpackage

// File: rtl/operand_shifter.sv
// rtl/operand_shifter.sv - combinational funnel shifter for operand_pipe
// Purpose: every shift flavour is a single 2*WIDTH-bit right shift of {hi,lo}.
// Ports:   i_hi    high word (used for pair shifts)
//          i_lo    shifted operand / low word
//          i_amt   shift amount
//          i_kind  logical, arithmetic, left or pair
//          o_result low WIDTH bits of the funnel output
module operand_shifter
  import operand_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         i_hi,
  input  logic [WIDTH-1:0]         i_lo,
  input  logic [$clog2(WIDTH)-1:0] i_amt,
  input  shift_kind_e              i_kind,
  output logic [WIDTH-1:0]         o_result
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] FULL_AMT = (SHW+1)'(WIDTH);

  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [SHW:0]     w_amt;

  always_comb begin
    w_hi  = i_hi;
    w_lo  = i_lo;
    w_amt = {1'b0, i_amt};
    case (i_kind)
      SH_LOGIC: w_hi = '0;
      SH_ARITH: w_hi = {WIDTH{i_lo[WIDTH-1]}};
      // x << n equals the low word of {x, 0} >> (WIDTH - n); n = 0 gives x.
      SH_LEFT: begin
        w_hi  = i_lo;
        w_lo  = '0;
        w_amt = FULL_AMT - {1'b0, i_amt};
      end
      SH_PAIR: w_hi = i_hi;
    endcase
  end

  assign o_result = WIDTH'({w_hi, w_lo} >> w_amt);

endmodule

// File: rtl/operand_pipe.sv
// rtl/operand_pipe.sv - two-stage operand preparation unit for the execute path
// Purpose: builds the second ALU operand (register, immediate, shift or pair
//          shift) with a valid/ready handshake, internal SAR and tag passthrough.
// Ports:   clk, rst                  clock, async active-high reset
//          in_valid/in_ready         request handshake
//          in_mode, in_ra, in_rb,
//          in_imm, in_tag            request payload
//          sar_we, sar_wdata         SAR write port
//          out_valid/out_ready       result handshake
//          out_data, out_tag, out_err result payload
module operand_pipe
  import operand_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_mode,
  input  logic [WIDTH-1:0]         in_ra,
  input  logic [WIDTH-1:0]         in_rb,
  input  logic [IMM_W-1:0]         in_imm,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic                     sar_we,
  input  logic [$clog2(WIDTH)-1:0] sar_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_err
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   r_sar;

  logic             r_s1_valid;
  logic [3:0]       r_s1_mode;
  logic [WIDTH-1:0] r_s1_ra;
  logic [WIDTH-1:0] r_s1_rb;
  logic [IMM_W-1:0] r_s1_imm;
  logic [TAG_W-1:0] r_s1_tag;
  logic [SHW-1:0]   r_s1_amt;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_err;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_accept;
  logic             w_use_sar;
  logic [SHW-1:0]   w_sh_imm;
  logic [SHW-1:0]   w_amt;
  shift_kind_e      w_kind;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_result;
  logic             w_err;

  // Stall chain: an empty stage never blocks the one behind it.
  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv && !rst;
  assign w_accept = in_valid && in_ready;

  // Shift amount is resolved at acceptance so a later SAR write cannot
  // retroactively change an op already in flight.
  assign w_use_sar = (in_mode >= 4'(MODE_SHRL_SAR)) && (in_mode <= 4'(MODE_SHRP));
  assign w_sh_imm  = SHW'(calc_sh_imm(in_imm[10:5], WIDTH));
  assign w_amt     = w_use_sar ? r_sar : w_sh_imm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sar <= '0;
    end else if (sar_we) begin
      r_sar <= sar_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 4'(MODE_PASS);
      r_s1_ra    <= '0;
      r_s1_rb    <= '0;
      r_s1_imm   <= '0;
      r_s1_tag   <= '0;
      r_s1_amt   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_mode <= in_mode;
        r_s1_ra   <= in_ra;
        r_s1_rb   <= in_rb;
        r_s1_imm  <= in_imm;
        r_s1_tag  <= in_tag;
        r_s1_amt  <= w_amt;
      end
    end
  end

  always_comb begin
    w_kind = SH_LOGIC;
    case (r_s1_mode)
      4'(MODE_SHRA), 4'(MODE_SHRA_SAR): w_kind = SH_ARITH;
      4'(MODE_SHL),  4'(MODE_SHL_SAR):  w_kind = SH_LEFT;
      4'(MODE_SHRP):                    w_kind = SH_PAIR;
      default:                          w_kind = SH_LOGIC;
    endcase
  end

  operand_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .i_hi     (r_s1_ra),
    .i_lo     (r_s1_rb),
    .i_amt    (r_s1_amt),
    .i_kind   (w_kind),
    .o_result (w_shift)
  );

  always_comb begin
    w_result = '0;
    w_err    = 1'b0;
    case (r_s1_mode)
      4'(MODE_PASS):  w_result = r_s1_rb;
      4'(MODE_IMM11): w_result = {{(WIDTH-11){r_s1_imm[10]}}, r_s1_imm[10:0]};
      4'(MODE_IMM14): w_result = {{(WIDTH-14){r_s1_imm[13]}}, r_s1_imm[13:0]};
      4'(MODE_IMM21): w_result = {r_s1_imm, {(WIDTH-IMM_W){1'b0}}};
      4'(MODE_SHRL), 4'(MODE_SHRA), 4'(MODE_SHL),
      4'(MODE_SHRL_SAR), 4'(MODE_SHRA_SAR), 4'(MODE_SHL_SAR),
      4'(MODE_SHRP):  w_result = w_shift;
      4'(MODE_ZERO):  w_result = '0;
      default:        w_err    = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
      r_out_err   <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      // Bubbles leave the last payload in place rather than clobbering it.
      if (r_s1_valid) begin
        r_out_data <= w_result;
        r_out_tag  <= r_s1_tag;
        r_out_err  <= w_err;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_operand_pipe.sv
// tb/tb_operand_pipe.sv - scoreboard testbench for operand_pipe (WIDTH = 32)
module tb_operand_pipe;

  typedef struct packed {
    logic        err;
    logic [3:0]  tag;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_mode;
  logic [31:0] in_ra;
  logic [31:0] in_rb;
  logic [20:0] in_imm;
  logic [3:0]  in_tag;
  logic        sar_we;
  logic [4:0]  sar_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        out_err;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [3:0]  next_tag = 4'd0;

  logic [31:0] exp_tab [8] = '{32'h8431FFEB, 32'hFFFFFF61, 32'h00000761, 32'h823B0800,
                               32'h08431FFE, 32'hF8431FFE, 32'h431FFEB0, 32'h00000000};

  operand_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_ra     (in_ra),
    .in_rb     (in_rb),
    .in_imm    (in_imm),
    .in_tag    (in_tag),
    .sar_we    (sar_we),
    .sar_wdata (sar_wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] mode, input logic [31:0] ra, input logic [31:0] rb,
                      input logic [31:0] exp_data, input logic exp_err, output int waits);
    exp_t e;
    bit   done;
    done     = 0;
    waits    = 0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_ra    = ra;
    in_rb    = rb;
    in_tag   = next_tag;
    e.err    = exp_err;
    e.tag    = next_tag;
    e.data   = exp_data;
    next_tag = next_tag + 4'd1;
    while (!done && waits < 50) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        done = 1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    sar_we   = 1'b0;
  endtask

  task automatic write_sar(input logic [4:0] v);
    sar_we    = 1'b1;
    sar_wdata = v;
    @(posedge clk);
    #1;
    sar_we    = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on every result transfer and
  // verifies the payload holds steady across a stalled cycle.
  initial begin
    exp_t e;
    exp_t held;
    bit   was_stalled;
    was_stalled = 0;
    held        = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        was_stalled = 0;
      end else begin
        if (was_stalled && out_valid) begin
          check("hold_data", 64'(out_data), 64'(held.data));
          check("hold_tag", 64'(out_tag), 64'(held.tag));
          check("hold_err", 64'(out_err), 64'(held.err));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 64'(out_data), 64'hDEAD_0000_0000);
          end else begin
            e = sb.pop_front();
            check("out_data", 64'(out_data), 64'(e.data));
            check("out_tag", 64'(out_tag), 64'(e.tag));
            check("out_err", 64'(out_err), 64'(e.err));
          end
        end
        was_stalled = out_valid && !out_ready;
        held        = {out_err, out_tag, out_data};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 4'd0;
    in_ra     = '0;
    in_rb     = '0;
    in_imm    = 21'h104761;
    in_tag    = '0;
    sar_we    = 1'b0;
    sar_wdata = '0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Two-cycle latency
    send(4'd0, 32'h0, 32'h8431FFEB, 32'h8431FFEB, 1'b0, w);
    @(negedge clk);
    check("latency_1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("latency_2", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;

    // Immediate and immediate-shift modes, back to back
    for (int m = 0; m < 8; m++) begin
      send(4'(m), 32'h0, 32'h8431FFEB, exp_tab[m], 1'b0, w);
      check("stream_wait", 64'(w), 64'd0);
    end
    drain();

    // SAR-driven modes
    write_sar(5'd8);
    send(4'd11, 32'h12345678, 32'h9ABCDEF0, 32'h789ABCDE, 1'b0, w);
    send(4'd9, 32'h0, 32'h80000000, 32'hFF800000, 1'b0, w);
    send(4'd8, 32'h0, 32'h80000000, 32'h00800000, 1'b0, w);
    drain();

    // SAR write in the same cycle as acceptance: old value applies
    write_sar(5'd1);
    sar_we    = 1'b1;
    sar_wdata = 5'd4;
    send(4'd10, 32'h0, 32'h1, 32'h2, 1'b0, w);
    send(4'd10, 32'h0, 32'h1, 32'h10, 1'b0, w);
    drain();

    // Backpressure: out_ready low for 3 cycles while 4 ops stream in
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          send(4'd0, 32'h0, 32'hA0 + 32'(i), 32'hA0 + 32'(i), 1'b0, w);
        end
      end
      begin
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_full_in_ready", 64'(in_ready), 64'd0);
        check("bp_full_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reserved mode then a normal op
    send(4'd13, 32'h0, 32'h8431FFEB, 32'h0, 1'b1, w);
    send(4'd0, 32'h0, 32'h8431FFEB, 32'h8431FFEB, 1'b0, w);
    drain();

    // Reset with two ops in flight
    out_ready = 1'b0;
    send(4'd10, 32'h0, 32'h1, 32'h10, 1'b0, w);
    send(4'd10, 32'h0, 32'h1, 32'h10, 1'b0, w);
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_out_data", 64'(out_data), 64'd0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_result", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(4'd10, 32'h0, 32'h1, 32'h1, 1'b0, w);
    send(4'd11, 32'hDEADBEEF, 32'h13579BDF, 32'h13579BDF, 1'b0, w);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
